// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
//   Arithmetic responder for the control unit's ALU interface. It accepts an
//   opcode and two WIDTH-bit operands under a 4-phase start/done handshake.
//   It produces a 2*WIDTH result, split into low and high halves.
//   ADD/SUB/logic/SLT finish in one step. MUL (shift-add) and DIV (restoring)
//   take ITER steps. A DIV by zero finishes in one step.
//
//   Ports
//     clk              clock, rising edge
//     reset            asynchronous, active-high reset
//     alu_start        request level; held high by the initiator until done
//     alu_opcode[2:0]  operation, sampled at acceptance
//     alu_a, alu_b     operands, sampled at acceptance
//     alu_result_low   result bits [WIDTH-1:0]
//     alu_result_high  result bits [2*WIDTH-1:WIDTH]
//     alu_done         result valid; held until alu_start drops
//     alu_busy         high in CALC and DONE
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for alu_start; operands latched on acceptance
//   CALC  | one step per edge; down-counter terminal count ends the op
//   DONE  | result and alu_done held until alu_start is seen low
// -----------------------------------------------------------------------------
module multicycle_alu #(
    parameter int WIDTH = 16,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_start,
    input  logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_result_low,
    output logic [WIDTH-1:0] alu_result_high,
    output logic             alu_done,
    output logic             alu_busy
);

    localparam int CW = $clog2(ITER + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    // acc_q: MUL partial product high half / DIV partial remainder.
    // mq_q : MUL multiplier shifting out LSB-first, product low half shifting in /
    //        DIV dividend shifting out MSB-first, quotient shifting in.
    logic [WIDTH-1:0] acc_q, mq_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] res_lo_q, res_hi_q;

    logic [WIDTH:0]   add_sum, sub_diff, mul_sum, div_shift, div_diff;
    logic             div_qbit;
    logic [WIDTH-1:0] acc_nxt, mq_nxt, lo_fin, hi_fin;
    logic             last_step;
    logic             load_long;

    assign last_step = (count_q == CW'(1));
    // A DIV by zero is resolved in a single step, so it loads the short count.
    assign load_long = (alu_opcode == OP_MUL) ||
                       ((alu_opcode == OP_DIV) && (alu_b != '0));

    always_comb begin
        add_sum   = {1'b0, a_q} + {1'b0, b_q};
        sub_diff  = {1'b0, a_q} - {1'b0, b_q};
        mul_sum   = mq_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        // When the trial subtract does not borrow, the shifted remainder was >= b.
        div_qbit  = ~div_diff[WIDTH];

        acc_nxt = acc_q;
        mq_nxt  = mq_q;
        case (op_q)
            OP_MUL: begin
                acc_nxt = mul_sum[WIDTH:1];
                mq_nxt  = {mul_sum[0], mq_q[WIDTH-1:1]};
            end
            OP_DIV: begin
                acc_nxt = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                mq_nxt  = {mq_q[WIDTH-2:0], div_qbit};
            end
            default: ;
        endcase

        lo_fin = '0;
        hi_fin = '0;
        case (op_q)
            OP_ADD: begin
                lo_fin = add_sum[WIDTH-1:0];
                hi_fin = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
            end
            OP_SUB: begin
                lo_fin = sub_diff[WIDTH-1:0];
                hi_fin = {{(WIDTH-1){1'b0}}, sub_diff[WIDTH]};
            end
            OP_MUL: begin
                lo_fin = mq_nxt;
                hi_fin = acc_nxt;
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    lo_fin = '1;
                    hi_fin = a_q;
                end else begin
                    lo_fin = mq_nxt;
                    hi_fin = acc_nxt;
                end
            end
            OP_AND: lo_fin = a_q & b_q;
            OP_OR:  lo_fin = a_q | b_q;
            OP_XOR: lo_fin = a_q ^ b_q;
            OP_SLT: lo_fin = {{(WIDTH-1){1'b0}}, sub_diff[WIDTH]};
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (alu_start)  state_nxt = CALC;
            CALC:    if (last_step)  state_nxt = DONE;
            DONE:    if (!alu_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            count_q  <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (alu_start) begin
                        op_q    <= alu_opcode;
                        a_q     <= alu_a;
                        b_q     <= alu_b;
                        acc_q   <= '0;
                        mq_q    <= alu_a;
                        count_q <= load_long ? CW'(ITER) : CW'(1);
                    end
                end
                CALC: begin
                    acc_q   <= acc_nxt;
                    mq_q    <= mq_nxt;
                    count_q <= count_q - CW'(1);
                    if (last_step) begin
                        res_lo_q <= lo_fin;
                        res_hi_q <= hi_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_result_low  = res_lo_q;
    assign alu_result_high = res_hi_q;
    assign alu_done        = (state == DONE);
    assign alu_busy        = (state != IDLE);

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         alu_start;
    logic [2:0]   alu_opcode;
    logic [W-1:0] alu_a, alu_b;
    logic [W-1:0] alu_result_low, alu_result_high;
    logic         alu_done, alu_busy;

    multicycle_alu #(.WIDTH(W), .ITER(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_start       (alu_start),
        .alu_opcode      (alu_opcode),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_result_low  (alu_result_low),
        .alu_result_high (alu_result_high),
        .alu_done        (alu_done),
        .alu_busy        (alu_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: latency from acceptance (busy rising) to done rising, then values.
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    int   accept_cyc = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (alu_busy && !prev_busy) accept_cyc = cyc;
            if (alu_done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {31'b0, alu_done}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_low"},  {16'b0, alu_result_low},  {16'b0, e.lo});
                    check({e.name, "_high"}, {16'b0, alu_result_high}, {16'b0, e.hi});
                    check({e.name, "_latency"}, cyc - accept_cyc, e.lat);
                end
            end
            prev_busy = alu_busy;
            prev_done = alu_done;
        end
    end

    // Called at a negedge. Issues the op, waits for done, holds start for `hold`
    // extra edges, drops it and checks done clears one edge later.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] lo, input logic [W-1:0] hi,
                          input int lat, input int hold, input bit scramble);
        exp_t e;
        bit   seen = 1'b0;
        e.name = name; e.lo = lo; e.hi = hi; e.lat = lat;
        exp_q.push_back(e);
        alu_opcode = op;
        alu_a      = a;
        alu_b      = b;
        alu_start  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (scramble && i == 0) begin
                alu_a      = 16'h1357;
                alu_b      = 16'h2468;
                alu_opcode = 3'b000;
            end
            if (alu_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, {31'b0, seen}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_done_held"}, {31'b0, alu_done}, 32'd1);
            check({name, "_low_held"},  {16'b0, alu_result_low}, {16'b0, lo});
        end
        alu_start = 1'b0;
        @(negedge clk);
        check({name, "_done_clear"}, {31'b0, alu_done}, 32'd0);
        check({name, "_busy_clear"}, {31'b0, alu_busy}, 32'd0);
        check({name, "_low_kept"},   {16'b0, alu_result_low}, {16'b0, lo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        alu_start  = 1'b1;   // start during reset must not be accepted
        alu_opcode = 3'b000;
        alu_a      = 16'h1111;
        alu_b      = 16'h2222;
        repeat (3) @(negedge clk);
        check("reset_done", {31'b0, alu_done}, 32'd0);
        check("reset_busy", {31'b0, alu_busy}, 32'd0);
        check("reset_low",  {16'b0, alu_result_low},  32'd0);
        check("reset_high", {16'b0, alu_result_high}, 32'd0);
        alu_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op("add_ovf",  3'b000, 16'hFFFF, 16'h0002, 16'h0001, 16'h0001, 1, 2, 1'b0);
        run_op("add_small",3'b000, 16'd1,    16'd2,    16'd3,    16'h0000, 1, 0, 1'b0);
        run_op("mul_full", 3'b010, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 16, 0, 1'b1);
        run_op("mul_small",3'b010, 16'd3,    16'd5,    16'd15,   16'h0000, 16, 0, 1'b0);
        run_op("div",      3'b011, 16'd1000, 16'd7,    16'd142,  16'd6,    16, 0, 1'b1);
        run_op("div_small",3'b011, 16'd7,    16'd1000, 16'd0,    16'd7,    16, 0, 1'b0);
        run_op("div_zero", 3'b011, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1, 0, 1'b0);
        // Handshake: start held 3 edges past done, then SUB issued right after IDLE.
        run_op("hs_add",   3'b000, 16'd10,   16'd20,   16'd30,   16'h0000, 1, 3, 1'b0);
        run_op("sub_brw",  3'b001, 16'd5,    16'd9,    16'hFFFC, 16'h0001, 1, 0, 1'b0);
        run_op("and",      3'b100, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 1, 0, 1'b0);
        run_op("or",       3'b101, 16'hF0F0, 16'h0FF0, 16'hFFF0, 16'h0000, 1, 0, 1'b0);
        run_op("xor",      3'b110, 16'hF0F0, 16'h0FF0, 16'hFF00, 16'h0000, 1, 0, 1'b0);
        run_op("slt_false",3'b111, 16'd9,    16'd4,    16'h0000, 16'h0000, 1, 0, 1'b0);

        // Reset 8 edges into a MUL: outputs clear at once and no done follows.
        alu_opcode = 3'b010;
        alu_a      = 16'h00FF;
        alu_b      = 16'h0101;
        alu_start  = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_mul_busy", {31'b0, alu_busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_done", {31'b0, alu_done}, 32'd0);
        check("rst_mid_busy", {31'b0, alu_busy}, 32'd0);
        check("rst_mid_low",  {16'b0, alu_result_low},  32'd0);
        check("rst_mid_high", {16'b0, alu_result_high}, 32'd0);
        alu_start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("no_done_after_rst", {31'b0, alu_done}, 32'd0);
        run_op("slt_true", 3'b111, 16'd3, 16'd4, 16'h0001, 16'h0000, 1, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
